// File: rtl/sc2110_sync_decode_module_pkg.sv
// sc2110_sync_pkg: shared constants and types for the SC2110 sync decoder.
//   - sync preamble words and the four sync code words
//   - frame FSM state enum
//   - o_err bit indices
//   - one-hot code hit struct passed from the detector to the top level
package sc2110_sync_pkg;

    localparam logic [11:0] PRE_0 = 12'hFFF;
    localparam logic [11:0] PRE_1 = 12'h000;
    localparam logic [11:0] PRE_2 = 12'h000;

    localparam logic [11:0] CODE_SAV_ACT = 12'h800;
    localparam logic [11:0] CODE_EAV_ACT = 12'h9D0;
    localparam logic [11:0] CODE_SAV_BLK = 12'hAB0;
    localparam logic [11:0] CODE_EAV_BLK = 12'hB60;

    localparam int unsigned ErrSync  = 0;
    localparam int unsigned ErrLine  = 1;
    localparam int unsigned ErrFrame = 2;

    typedef enum logic [1:0] {
        StWaitBlk,
        StBlank,
        StActive,
        StBetween
    } sync_state_e;

    // Exactly one bit is set when a complete sync sequence ends; bad = preamble + non-code.
    typedef struct packed {
        logic sav_act;
        logic eav_act;
        logic sav_blk;
        logic eav_blk;
        logic bad;
    } code_hit_t;

    function automatic logic is_code(logic [11:0] w);
        return (w == CODE_SAV_ACT) || (w == CODE_EAV_ACT) ||
               (w == CODE_SAV_BLK) || (w == CODE_EAV_BLK);
    endfunction

endpackage

// File: rtl/sc2110_sync_decode_module_if.sv
// sc2110_sync_decode_module_if: pixel stream in, framed pixel stream out.
//   i_dvld/i_data            : sample stream from the lane decoder
//   o_data/o_dvld            : active pixels
//   o_line_vld/o_frame_vld   : framing levels
//   o_sof/o_eol/o_err[2:0]   : one-cycle framing and error pulses
// master: the source/sink around the decoder; slave: the decoder itself.
interface sc2110_sync_decode_module_if;

    logic        i_dvld;
    logic [11:0] i_data;
    logic [11:0] o_data;
    logic        o_dvld;
    logic        o_line_vld;
    logic        o_frame_vld;
    logic        o_sof;
    logic        o_eol;
    logic [2:0]  o_err;

    modport master (
        output i_dvld, i_data,
        input  o_data, o_dvld, o_line_vld, o_frame_vld, o_sof, o_eol, o_err
    );

    modport slave (
        input  i_dvld, i_data,
        output o_data, o_dvld, o_line_vld, o_frame_vld, o_sof, o_eol, o_err
    );

endinterface

// File: rtl/sc2110_sync_detect.sv
// sc2110_sync_detect: 3-deep delay line plus preamble/code matcher.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   dvld_i/data_i : input sample stream; gaps stall the delay line
//   cand_o/cand_vld_o : pixel candidate (oldest delayed sample) shifted out this cycle
//   hit_o         : one-hot code hit, valid in the cycle the code word is sampled
// Outputs are combinational from the current sample; the top level registers them.
module sc2110_sync_detect
    import sc2110_sync_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        dvld_i,
    input  logic [11:0] data_i,
    output logic [11:0] cand_o,
    output logic        cand_vld_o,
    output code_hit_t   hit_o
);

    // Index 0 holds the oldest sample.
    logic [2:0][11:0] dly_q, dly_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pre_match;

    assign pre_match = (cnt_q == 2'd3) && (dly_q[0] == PRE_0) &&
                       (dly_q[1] == PRE_1) && (dly_q[2] == PRE_2);
    assign cand_o    = dly_q[0];

    always_comb begin
        dly_d      = dly_q;
        cnt_d      = cnt_q;
        cand_vld_o = 1'b0;
        hit_o      = '0;
        if (dvld_i) begin
            if (pre_match && is_code(data_i)) begin
                // Preamble and code are swallowed: empty the line, emit nothing.
                cnt_d         = 2'd0;
                hit_o.sav_act = (data_i == CODE_SAV_ACT);
                hit_o.eav_act = (data_i == CODE_EAV_ACT);
                hit_o.sav_blk = (data_i == CODE_SAV_BLK);
                hit_o.eav_blk = (data_i == CODE_EAV_BLK);
            end else begin
                // A broken sequence is flagged but flows through as ordinary pixels.
                hit_o.bad = pre_match;
                dly_d     = {data_i, dly_q[2], dly_q[1]};
                if (cnt_q == 2'd3) begin
                    cand_vld_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dly_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            dly_q <= dly_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc2110_sync_decode_module.sv
// sc2110_sync_decode_module: strips embedded sync words from the SC2110 pixel
// stream and emits active pixels with line/frame framing.
//   i_clk, i_rstn : pixel clock, asynchronous active-low reset
//   vid_io        : stream interface (slave side), see sc2110_sync_decode_module_if
// Parameters P_H_ACTIVE / P_V_ACTIVE give the expected line length and frame
// height; they only matter when SC2110_FRAME_CHECK_EN is defined, which adds
// per-line pixel and per-frame line counters driving o_err[1] and o_err[2].
// Without the macro those error bits are tied low.
module sc2110_sync_decode_module
    import sc2110_sync_pkg::*;
#(
    parameter int unsigned P_H_ACTIVE = 1920,
    parameter int unsigned P_V_ACTIVE = 1080
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    sc2110_sync_decode_module_if.slave        vid_io
);

    logic [11:0] cand;
    logic        cand_vld;
    code_hit_t   hit;

    sc2110_sync_detect u_detect (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .dvld_i     (vid_io.i_dvld),
        .data_i     (vid_io.i_data),
        .cand_o     (cand),
        .cand_vld_o (cand_vld),
        .hit_o      (hit)
    );

    sync_state_e state_q, state_d;
    logic        sof_arm_q, sof_arm_d;
    logic [11:0] data_q, data_d;
    logic        dvld_q, dvld_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic [2:0]  err_q, err_d;
    logic        emit;
    logic        err_sync;
    logic        err_len;
    logic        err_height;

    // EAV_BLK inside blanking carries no information for this block.
    logic unused_eav_blk;
    assign unused_eav_blk = hit.eav_blk;

    assign emit = cand_vld && (state_q == StActive);

    always_comb begin
        state_d   = state_q;
        sof_arm_d = sof_arm_q;
        data_d    = data_q;
        dvld_d    = 1'b0;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        err_sync  = hit.bad;
        if (emit) begin
            dvld_d    = 1'b1;
            data_d    = cand;
            sof_d     = sof_arm_q;
            sof_arm_d = 1'b0;
        end
        case (state_q)
            StWaitBlk: begin
                if (hit.sav_blk) state_d = StBlank;
                if (hit.eav_act) err_sync = 1'b1;
            end
            StBlank: begin
                if (hit.sav_act) begin
                    state_d   = StActive;
                    sof_arm_d = 1'b1;
                end
                if (hit.eav_act) err_sync = 1'b1;
            end
            StActive: begin
                if (hit.eav_act) begin
                    state_d = StBetween;
                    eol_d   = 1'b1;
                end
                // Missing EAV: stay in the line, the pixel counter restarts.
                if (hit.sav_act) err_sync = 1'b1;
            end
            StBetween: begin
                if (hit.sav_act) state_d = StActive;
                if (hit.sav_blk) state_d = StBlank;
                if (hit.eav_act) err_sync = 1'b1;
            end
            default: state_d = StWaitBlk;
        endcase
    end

`ifdef SC2110_FRAME_CHECK_EN
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        line_start, frame_start, line_end, frame_end;

    assign line_start  = hit.sav_act && (state_q != StWaitBlk);
    assign frame_start = hit.sav_act && (state_q == StBlank);
    assign line_end    = hit.eav_act && (state_q == StActive);
    assign frame_end   = hit.sav_blk && (state_q == StBetween);

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        if (line_start) begin
            pix_cnt_d = '0;
        end else if (emit && (pix_cnt_q != '1)) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
        end
        if (frame_start) begin
            line_cnt_d = '0;
        end else if (line_end && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign err_len    = line_end && (pix_cnt_q != 12'(P_H_ACTIVE));
    assign err_height = frame_end && (line_cnt_q != 11'(P_V_ACTIVE));
`else
    logic unused_dims;
    assign unused_dims = ^{P_H_ACTIVE, P_V_ACTIVE};
    assign err_len     = 1'b0;
    assign err_height  = 1'b0;
`endif

    always_comb begin
        err_d           = '0;
        err_d[ErrSync]  = err_sync;
        err_d[ErrLine]  = err_len;
        err_d[ErrFrame] = err_height;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StWaitBlk;
            sof_arm_q <= 1'b0;
            data_q    <= '0;
            dvld_q    <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            sof_arm_q <= sof_arm_d;
            data_q    <= data_d;
            dvld_q    <= dvld_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            err_q     <= err_d;
        end
    end

    assign vid_io.o_data      = data_q;
    assign vid_io.o_dvld      = dvld_q;
    assign vid_io.o_line_vld  = (state_q == StActive);
    assign vid_io.o_frame_vld = (state_q == StActive) || (state_q == StBetween);
    assign vid_io.o_sof       = sof_q;
    assign vid_io.o_eol       = eol_q;
    assign vid_io.o_err       = err_q;

endmodule

// File: tb/tb_sc2110_sync_decode_module.sv
// Self-checking bench for sc2110_sync_decode_module. A sample-level reference
// model predicts every output for the cycle after each input sample; directed
// scenarios add aggregate checks on top, then randomized frames follow.
module tb_sc2110_sync_decode_module;

    localparam int PH = 8;
    localparam int PV = 4;

    localparam logic [11:0] SAV_ACT = 12'h800;
    localparam logic [11:0] EAV_ACT = 12'h9D0;
    localparam logic [11:0] SAV_BLK = 12'hAB0;
    localparam logic [11:0] EAV_BLK = 12'hB60;

    typedef enum int {MWait, MBlank, MActive, MBetween} m_state_e;

    logic i_clk;
    logic i_rstn;

    sc2110_sync_decode_module_if vid ();

    sc2110_sync_decode_module #(
        .P_H_ACTIVE (PH),
        .P_V_ACTIVE (PV)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .vid_io (vid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [11:0] hist[$];
    m_state_e    mst;
    bit          m_arm;
    int          m_pix;
    int          m_lines;

    // Expected outputs for the coming cycle
    logic        e_dvld, e_sof, e_eol;
    logic [11:0] e_data;
    logic [2:0]  e_err;

    // Observed tallies
    int          n_dvld, n_sof, n_eol, n_err0, n_err1, n_err2, n_frame;
    logic [11:0] obs_data[$];

    int gap_mode = 0;
    int n_sent   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_code_w(logic [11:0] w);
        return (w == SAV_ACT) || (w == EAV_ACT) || (w == SAV_BLK) || (w == EAV_BLK);
    endfunction

    task automatic model_reset();
        hist.delete();
        mst     = MWait;
        m_arm   = 1'b0;
        m_pix   = 0;
        m_lines = 0;
    endtask

    task automatic clr_tally();
        n_dvld = 0; n_sof = 0; n_eol = 0; n_err0 = 0; n_err1 = 0; n_err2 = 0; n_frame = 0;
        obs_data.delete();
    endtask

    task automatic apply_code(input logic [11:0] c);
        case (mst)
            MWait: begin
                if (c == SAV_BLK) mst = MBlank;
                else if (c == EAV_ACT) e_err[0] = 1'b1;
            end
            MBlank: begin
                if (c == SAV_ACT) begin
                    mst = MActive; m_arm = 1'b1; m_pix = 0; m_lines = 0;
                end else if (c == EAV_ACT) e_err[0] = 1'b1;
            end
            MActive: begin
                if (c == EAV_ACT) begin
                    mst = MBetween;
                    e_eol = 1'b1;
`ifdef SC2110_FRAME_CHECK_EN
                    if (m_pix != PH) e_err[1] = 1'b1;
`endif
                    m_lines++;
                end else if (c == SAV_ACT) begin
                    e_err[0] = 1'b1;
                    m_pix = 0;
                end
            end
            MBetween: begin
                if (c == SAV_ACT) begin
                    mst = MActive; m_pix = 0;
                end else if (c == SAV_BLK) begin
                    mst = MBlank;
`ifdef SC2110_FRAME_CHECK_EN
                    if (m_lines != PV) e_err[2] = 1'b1;
`endif
                end else if (c == EAV_ACT) e_err[0] = 1'b1;
            end
            default: mst = MWait;
        endcase
    endtask

    // One clock: drive a sample (or idle), predict, then check 1 time unit after the edge.
    task automatic step(input bit dv, input logic [11:0] d);
        bit          pre;
        logic [11:0] cand;
        e_dvld = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_data = '0; e_err = '0;
        vid.i_dvld = dv;
        vid.i_data = dv ? d : 12'($urandom);
        if (dv) begin
            pre = (hist.size() == 3) && (hist[0] == 12'hFFF) && (hist[1] == 12'h000) &&
                  (hist[2] == 12'h000);
            if (pre && is_code_w(d)) begin
                hist.delete();
                apply_code(d);
            end else begin
                if (pre) e_err[0] = 1'b1;
                if (hist.size() == 3) begin
                    cand = hist.pop_front();
                    if (mst == MActive) begin
                        e_dvld = 1'b1; e_data = cand; e_sof = m_arm; m_arm = 1'b0; m_pix++;
                    end
                end
                hist.push_back(d);
            end
        end
        @(posedge i_clk);
        #1;
        vid.i_dvld = 1'b0;
        chk("dvld", 32'(vid.o_dvld), 32'(e_dvld));
        if (e_dvld) chk("data", 32'(vid.o_data), 32'(e_data));
        chk("sof", 32'(vid.o_sof), 32'(e_sof));
        chk("eol", 32'(vid.o_eol), 32'(e_eol));
        chk("err", 32'(vid.o_err), 32'(e_err));
        chk("line_vld", 32'(vid.o_line_vld), 32'(mst == MActive));
        chk("frame_vld", 32'(vid.o_frame_vld), 32'((mst == MActive) || (mst == MBetween)));
        if (vid.o_dvld) begin
            n_dvld++;
            obs_data.push_back(vid.o_data);
        end
        if (vid.o_sof) n_sof++;
        if (vid.o_eol) n_eol++;
        if (vid.o_err[0]) n_err0++;
        if (vid.o_err[1]) n_err1++;
        if (vid.o_err[2]) n_err2++;
        if (vid.o_frame_vld) n_frame++;
    endtask

    task automatic send(input logic [11:0] d);
        int k;
        step(1'b1, d);
        n_sent++;
        if (gap_mode == 1 && (n_sent % 4) == 0) begin
            step(1'b0, '0);
            step(1'b0, '0);
        end else if (gap_mode == 2) begin
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            repeat (k) step(1'b0, '0);
        end
    endtask

    task automatic send_code(input logic [11:0] c);
        send(12'hFFF);
        send(12'h000);
        send(12'h000);
        send(c);
    endtask

    task automatic send_line(input int n, input int base);
        send_code(SAV_ACT);
        for (int i = 0; i < n; i++) send(12'(base + i));
        send_code(EAV_ACT);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(vid.o_data), 32'h0);
        chk({tag, "_dvld"}, 32'(vid.o_dvld), 32'h0);
        chk({tag, "_line"}, 32'(vid.o_line_vld), 32'h0);
        chk({tag, "_frame"}, 32'(vid.o_frame_vld), 32'h0);
        chk({tag, "_sof"}, 32'(vid.o_sof), 32'h0);
        chk({tag, "_eol"}, 32'(vid.o_eol), 32'h0);
        chk({tag, "_err"}, 32'(vid.o_err), 32'h0);
    endtask

    // Called 1 unit after a rising edge; reset asserts between edges.
    task automatic do_reset();
        #2 i_rstn = 1'b0;
        #1 chk_all_zero("rst_async");
        model_reset();
        vid.i_dvld = 1'b1;
        vid.i_data = 12'hFFF;
        @(posedge i_clk);
        #1 chk_all_zero("rst_hold");
        vid.i_dvld = 1'b0;
        #3 i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    logic [11:0] exp4[8];

    initial begin
        i_rstn     = 1'b0;
        vid.i_dvld = 1'b0;
        vid.i_data = '0;
        model_reset();
        clr_tally();
        #1 chk_all_zero("por");
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #3 i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic frame lock, one 8-pixel line, continuous valid.
        clr_tally();
        gap_mode = 0;
        send_code(SAV_BLK);
        send_line(8, 1);
        repeat (3) step(1'b0, '0);
        chk("t1_npix", 32'(n_dvld), 32'd8);
        chk("t1_nsof", 32'(n_sof), 32'd1);
        chk("t1_neol", 32'(n_eol), 32'd1);
        for (int i = 0; i < 8; i++) chk("t1_seq", 32'(obs_data[i]), 32'(i + 1));

        // Same stream with two idle cycles every four samples.
        do_reset();
        clr_tally();
        gap_mode = 1;
        n_sent = 0;
        send_code(SAV_BLK);
        send_line(8, 1);
        repeat (3) step(1'b0, '0);
        gap_mode = 0;
        chk("t2_npix", 32'(n_dvld), 32'd8);
        chk("t2_nsof", 32'(n_sof), 32'd1);
        for (int i = 0; i < 8; i++) chk("t2_seq", 32'(obs_data[i]), 32'(i + 1));

        // No SAV_BLK: the decoder must stay unlocked.
        do_reset();
        clr_tally();
        send_line(8, 1);
        repeat (3) step(1'b0, '0);
        chk("t3_npix", 32'(n_dvld), 32'd0);
        chk("t3_frame", 32'(n_frame), 32'd0);

        // Broken sync inside a line flows through as pixels.
        do_reset();
        clr_tally();
        send_code(SAV_BLK);
        send_code(SAV_ACT);
        send(12'd1); send(12'd2);
        send(12'hFFF); send(12'h000); send(12'h000); send(12'h123);
        send(12'd5); send(12'd6);
        send_code(EAV_ACT);
        repeat (3) step(1'b0, '0);
        exp4 = '{12'd1, 12'd2, 12'hFFF, 12'h000, 12'h000, 12'h123, 12'd5, 12'd6};
        chk("t4_npix", 32'(n_dvld), 32'd8);
        chk("t4_nerr0", 32'(n_err0), 32'd1);
        for (int i = 0; i < 8; i++) chk("t4_seq", 32'(obs_data[i]), 32'(exp4[i]));

        // Short line and short frame.
        do_reset();
        clr_tally();
        send_code(SAV_BLK);
        send_line(7, 16);
        send_line(8, 32);
        send_line(8, 48);
        send_code(SAV_BLK);
        repeat (2) step(1'b0, '0);
        chk("t5_npix", 32'(n_dvld), 32'd23);
`ifdef SC2110_FRAME_CHECK_EN
        chk("t5_nerr1", 32'(n_err1), 32'd1);
        chk("t5_nerr2", 32'(n_err2), 32'd1);
`else
        chk("t5_nerr1", 32'(n_err1), 32'd0);
        chk("t5_nerr2", 32'(n_err2), 32'd0);
`endif

        // Reset in the middle of a line, then relock only after SAV_BLK.
        do_reset();
        send_code(SAV_BLK);
        send_code(SAV_ACT);
        for (int i = 0; i < 5; i++) send(12'(100 + i));
        do_reset();
        clr_tally();
        send_line(6, 200);
        repeat (2) step(1'b0, '0);
        chk("t6_idle_npix", 32'(n_dvld), 32'd0);
        chk("t6_idle_frame", 32'(n_frame), 32'd0);
        clr_tally();
        send_code(SAV_BLK);
        send_line(4, 300);
        repeat (2) step(1'b0, '0);
        chk("t6_npix", 32'(n_dvld), 32'd4);
        chk("t6_nsof", 32'(n_sof), 32'd1);

        // Randomized frames with random gaps, junk and broken syncs.
        do_reset();
        gap_mode = 2;
        for (int f = 0; f < 8; f++) begin
            int nl;
            send_code(SAV_BLK);
            repeat ($urandom_range(0, 4)) send(12'($urandom));
            if ($urandom_range(0, 2) == 0) send_code(EAV_BLK);
            nl = $urandom_range(2, 5);
            for (int l = 0; l < nl; l++) begin
                send_code(SAV_ACT);
                repeat ($urandom_range(4, 12)) send(12'($urandom));
                if ($urandom_range(0, 5) == 0) send_code(12'($urandom));
                if ($urandom_range(0, 7) == 0) send_code(SAV_ACT);
                repeat ($urandom_range(0, 4)) send(12'($urandom));
                send_code(EAV_ACT);
                if ($urandom_range(0, 7) == 0) send_code(EAV_ACT);
            end
        end
        send_code(SAV_BLK);
        gap_mode = 0;
        repeat (3) step(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc2110_sync_decode_module.md
# sc2110_sync_decode_module

Downstream of the SC2110 48-to-12 lane decoder. Consumes the bursty 12-bit pixel stream (`i_dvld` high in groups of four), locates embedded sync words and strips them. Emits active pixels with line/frame framing signals and error pulses to the video capture logic. All logic runs in the single `i_clk` domain shared with the decoder.

## Interface
- `P_H_ACTIVE`, 1920: expected active pixels per line (used only with the check feature).
- `P_V_ACTIVE`, 1080: expected active lines per frame (used only with the check feature).
- `i_clk`  in  1  pixel clock.
- `i_rstn`  in  1  reset: asynchronous, active-low.
- `i_dvld`  in  1  input sample valid.
- `i_data`  in  12  input sample.
- `o_data`  out  12  active pixel; reset 0.
- `o_dvld`  out  1  `o_data` valid; reset 0.
- `o_line_vld`  out  1  level, inside an active line; reset 0.
- `o_frame_vld`  out  1  level, inside an active frame; reset 0.
- `o_sof`  out  1  one-cycle pulse with the first pixel of a frame; reset 0.
- `o_eol`  out  1  one-cycle pulse on active-line EAV detection; reset 0.
- `o_err`  out  3  one-cycle error pulses; reset 0. [0] sync code error, [1] line length, [2] frame height.

## Operation
- Sync sequence is four consecutive valid samples: 12'hFFF, 12'h000, 12'h000, then a code word. Codes:
  - SAV_ACT 12'h800
  - EAV_ACT 12'h9D0
  - SAV_BLK 12'hAB0
  - EAV_BLK 12'hB60
- Delay line holds the last 3 valid samples. When a new valid sample arrives and the line is full, the oldest sample is the pixel candidate.
- If the delay line equals the preamble and the new sample is a code, the 3 delayed samples are discarded. The line is emptied and the code is not emitted.
- A preamble followed by a non-code word raises `o_err[0]` and is treated as pixel data.
- State machine, reset state WAIT_BLK:
  - WAIT_BLK -> BLANK on SAV_BLK. No output before frame lock.
  - BLANK -> ACTIVE on SAV_ACT: `o_line_vld` = 1, `o_frame_vld` = 1, arm `o_sof` for the next emitted pixel.
  - ACTIVE -> BETWEEN on EAV_ACT: `o_line_vld` = 0, `o_eol` pulse.
  - BETWEEN -> ACTIVE on SAV_ACT, new line.
  - BETWEEN -> BLANK on SAV_BLK: `o_frame_vld` = 0.
  - BLANK and EAV_BLK: no transition.
- Pixels are emitted only in ACTIVE. Candidates in other states are dropped.
- Error `o_err[0]` also fires on:
  - SAV_ACT in ACTIVE (missing EAV): the line restarts and the pixel counter clears.
  - EAV_ACT outside ACTIVE: ignored.
  - Any undefined code word.
- Reset mid-frame: all outputs clear immediately. The delay line empties and the block returns to WAIT_BLK, so it relocks only at the next blanking line.

## Timing
- `o_data`/`o_dvld` are registered. They assert the cycle after the `i_dvld` that shifts the pixel out of the delay line.
- Pixel latency is 3 valid samples plus 1 clock. Gaps in `i_dvld` stall the delay line; there is no timeout.
- Framing outputs (`o_line_vld` edges, `o_eol`, `o_err`) assert the cycle after the code word is sampled.
- `o_sof` coincides with the first `o_dvld` after a BLANK->ACTIVE transition.
- The last pixel of a line is emitted before the EAV preamble completes, so `o_eol` always trails the last `o_dvld`.

## Configuration
- `SC2110_FRAME_CHECK_EN` defined:
  - A 12-bit pixel counter per line and an 11-bit line counter per frame.
  - At EAV_ACT, pixel count ≠ `P_H_ACTIVE` pulses `o_err[1]`.
  - At the ACTIVE-frame end (SAV_BLK in BETWEEN), line count ≠ `P_V_ACTIVE` pulses `o_err[2]`.
  - Counters saturate at their maximum value.
- Undefined: counters are absent and `o_err[2:1]` is tied to 0.

## Structure
- Package `sc2110_sync_pkg`: preamble constants, the four code constants, the state enum (WAIT_BLK, BLANK, ACTIVE, BETWEEN) and the `o_err` bit indices.
- Sub-module `sc2110_sync_detect`: 3-deep delay line plus preamble/code matcher. Outputs are the pixel candidate with its valid, plus a one-hot code hit (SAV_ACT, EAV_ACT, SAV_BLK, EAV_BLK, bad).
- Top level contains the FSM, output registers and the optional counters.

## Test plan
- SAV_BLK, then SAV_ACT, 8 pixels 1..8, EAV_ACT -> `o_dvld` ×8 with data 1..8; `o_sof` with pixel 1; `o_eol` once; no preamble words on `o_data`.
- Same stream with 2-cycle `i_dvld` gaps every 4 samples -> identical `o_data` sequence; latency per pixel is 3 valid samples + 1 clk.
- Stream without a preceding SAV_BLK -> no `o_dvld`, `o_frame_vld` stays 0.
- FFF,000,000,12'h123 inside a line -> `o_err[0]` pulse; the four samples are emitted as pixels.
- `SC2110_FRAME_CHECK_EN`, `P_H_ACTIVE`=8: a 7-pixel line -> `o_err[1]` at EAV. 3 lines with `P_V_ACTIVE`=4 -> `o_err[2]` at the closing SAV_BLK.
- `i_rstn` low mid-line -> all outputs 0 within the reset. After release, output stays idle until SAV_BLK followed by SAV_ACT.
